// File: rtl/cp0_int_ctrl.sv
// rtl/cp0_int_ctrl.sv - CP0 interrupt/exception controller (SR, Cause, EPC, PRId).
// Optional delay-slot EPC/BD tracking is enabled by defining CP0_BD_EN.
module cp0_int_ctrl #(
  parameter logic [31:0] PRID    = 32'h0000_7F01,
  parameter logic [31:0] EPC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic [31:0] PC,
  input  logic        ExcValid,
  input  logic [4:0]  ExcCode,
  input  logic        BDIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc_q;
  logic        bd;
  logic        int_pend;
  logic        exc_pend;
  logic [31:0] pc_word;

  assign pc_word  = {PC[31:2], 2'b00};
  assign int_pend = (|(HWInt & im)) & ie & ~exl;
  assign exc_pend = ExcValid & ~exl;
  assign IntReq   = int_pend | exc_pend;
  assign EPC      = epc_q;

  // A flushed mtc0 (We with IntReq) must not touch any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= 6'b0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      ip       <= 6'b0;
      exc_code <= 5'b0;
      epc_q    <= EPC_RST;
    end else begin
      ip <= HWInt;
      if (IntReq) begin
        exl      <= 1'b1;
        exc_code <= int_pend ? 5'd0 : ExcCode;
`ifdef CP0_BD_EN
        epc_q    <= BDIn ? (pc_word - 32'd4) : pc_word;
`else
        epc_q    <= pc_word;
`endif
      end else begin
        if (We && A2 == 5'd12) begin
          im  <= DIn[15:10];
          exl <= DIn[1];
          ie  <= DIn[0];
        end
        if (We && A2 == 5'd14)
          epc_q <= {DIn[31:2], 2'b00};
        if (EXLClr)
          exl <= 1'b0;
      end
    end
  end

`ifdef CP0_BD_EN
  always_ff @(posedge clk) begin
    if (reset)
      bd <= 1'b0;
    else if (IntReq)
      bd <= BDIn;
  end
`else
  logic unused_bd;
  assign bd        = 1'b0;
  assign unused_bd = BDIn;
`endif

  logic unused_pc;
  assign unused_pc = ^PC[1:0];

  always_comb begin
    DOut = 32'b0;
    case (A1)
      5'd12:   DOut = {16'b0, im, 8'b0, exl, ie};
      5'd13:   DOut = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
      5'd14:   DOut = epc_q;
      5'd15:   DOut = PRID;
      default: DOut = 32'b0;
    endcase
  end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// tb/tb_cp0_int_ctrl.sv - directed vector table plus randomized model check for cp0_int_ctrl.
module tb_cp0_int_ctrl;

  localparam logic [31:0] PRID    = 32'h0000_7F01;
  localparam logic [31:0] EPC_RST = 32'h0000_0000;
`ifdef CP0_BD_EN
  localparam bit BD_ON = 1'b1;
`else
  localparam bit BD_ON = 1'b0;
`endif
  localparam logic [31:0] EPC_BD   = BD_ON ? 32'h0000_3020 : 32'h0000_3024;
  localparam logic [31:0] CAUSE_BD = BD_ON ? 32'h8000_0028 : 32'h0000_0028;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, ExcCode;
  logic [31:0] DIn, PC, EPC, DOut;
  logic        We, ExcValid, BDIn, EXLClr, IntReq;
  logic [5:0]  HWInt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cp0_int_ctrl #(.PRID(PRID), .EPC_RST(EPC_RST)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .We(We), .PC(PC),
    .ExcValid(ExcValid), .ExcCode(ExcCode), .BDIn(BDIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
  );

  typedef struct {
    logic        we;
    logic [4:0]  a2;
    logic [31:0] din;
    logic [5:0]  hw;
    logic        ev;
    logic [4:0]  ec;
    logic        bdi;
    logic        clr;
    logic [31:0] pc;
    logic [4:0]  a1;
    logic        ireq;
    logic [31:0] dout;
  } vec_t;

  function automatic vec_t mk(logic we, logic [4:0] a2, logic [31:0] din, logic [5:0] hw,
                              logic ev, logic [4:0] ec, logic bdi, logic clr,
                              logic [31:0] pc, logic [4:0] a1, logic ireq, logic [31:0] dout);
    vec_t v;
    v.we = we; v.a2 = a2; v.din = din; v.hw = hw; v.ev = ev; v.ec = ec;
    v.bdi = bdi; v.clr = clr; v.pc = pc; v.a1 = a1; v.ireq = ireq; v.dout = dout;
    return v;
  endfunction

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    We = v.we; A2 = v.a2; DIn = v.din; HWInt = v.hw; ExcValid = v.ev;
    ExcCode = v.ec; BDIn = v.bdi; EXLClr = v.clr; PC = v.pc; A1 = v.a1;
  endtask

  // Drive one vector, check outputs mid-cycle, then let the clock edge happen.
  task automatic apply(string name, vec_t v);
    drive(v);
    #2;
    check32({name, " IntReq"}, {31'b0, IntReq}, {31'b0, v.ireq});
    check32({name, " DOut"}, DOut, v.dout);
    if (v.a1 == 5'd14) check32({name, " EPC"}, EPC, v.dout);
    @(posedge clk); #1;
  endtask

  // Behavioural reference state.
  logic [5:0]  m_im, m_ip;
  logic        m_ie, m_exl, m_bd;
  logic [4:0]  m_code;
  logic [31:0] m_epc;

  task automatic m_reset();
    m_im = 0; m_ip = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_code = 0; m_epc = EPC_RST;
  endtask

  function automatic bit m_int(logic [5:0] hw);
    bit any = 0;
    for (int i = 0; i < 6; i++) if (hw[i] && m_im[i]) any = 1;
    return any && m_ie && !m_exl;
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a);
    case (a)
      5'd12: return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13: return (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_code) << 2);
      5'd14: return m_epc;
      5'd15: return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_step(vec_t v, bit rst);
    bit ip_, take;
    ip_  = m_int(v.hw);
    take = ip_ || (v.ev && !m_exl);
    if (rst) begin
      m_reset();
      return;
    end
    m_ip = v.hw;
    if (take) begin
      m_exl  = 1;
      m_code = ip_ ? 5'd0 : v.ec;
      m_epc  = (v.pc / 4) * 4;
      m_bd   = 0;
      if (BD_ON && v.bdi) begin
        m_epc = m_epc - 4;
        m_bd  = 1;
      end
    end else begin
      if (v.we && v.a2 == 12) begin
        m_im = v.din[15:10]; m_exl = v.din[1]; m_ie = v.din[0];
      end
      if (v.we && v.a2 == 14) m_epc = (v.din / 4) * 4;
      if (v.clr) m_exl = 0;
    end
  endtask

  vec_t tbl[31];
  vec_t rv;

  initial begin
    //              we a2    din           hw      ev ec  bdi clr pc            a1  ireq dout
    tbl[0]  = mk(0, 0,  0,            6'h00, 0, 0,  0, 0, 0,            12, 0, 32'h0);
    tbl[1]  = mk(0, 0,  0,            6'h00, 0, 0,  0, 0, 0,            13, 0, 32'h0);
    tbl[2]  = mk(0, 0,  0,            6'h00, 0, 0,  0, 0, 0,            14, 0, EPC_RST);
    tbl[3]  = mk(0, 0,  0,            6'h00, 0, 0,  0, 0, 0,            15, 0, PRID);
    tbl[4]  = mk(1, 12, 32'h401,      6'h01, 0, 0,  0, 0, 32'h3010,     12, 0, 32'h0);
    tbl[5]  = mk(0, 0,  0,            6'h01, 0, 0,  0, 0, 32'h3010,     12, 1, 32'h401);
    tbl[6]  = mk(0, 0,  0,            6'h01, 0, 0,  0, 0, 0,            12, 0, 32'h403);
    tbl[7]  = mk(0, 0,  0,            6'h01, 0, 0,  0, 0, 0,            13, 0, 32'h400);
    tbl[8]  = mk(0, 0,  0,            6'h01, 0, 0,  0, 0, 0,            14, 0, 32'h3010);
    tbl[9]  = mk(0, 0,  0,            6'h3F, 1, 4,  0, 0, 0,            13, 0, 32'h400);
    tbl[10] = mk(0, 0,  0,            6'h3F, 1, 4,  0, 0, 0,            13, 0, 32'hFC00);
    tbl[11] = mk(0, 0,  0,            6'h01, 0, 0,  0, 1, 0,            12, 0, 32'h403);
    tbl[12] = mk(0, 0,  0,            6'h01, 0, 0,  0, 0, 32'h3040,     12, 1, 32'h401);
    tbl[13] = mk(1, 12, 32'h803,      6'h01, 0, 0,  0, 1, 0,            12, 0, 32'h403);
    tbl[14] = mk(0, 0,  0,            6'h01, 0, 0,  0, 0, 0,            12, 0, 32'h801);
    tbl[15] = mk(0, 0,  0,            6'h02, 0, 0,  0, 0, 32'h3050,     13, 1, 32'h400);
    tbl[16] = mk(0, 0,  0,            6'h00, 0, 0,  0, 1, 0,            13, 0, 32'h800);
    tbl[17] = mk(0, 0,  0,            6'h02, 1, 4,  0, 0, 32'h3060,     14, 1, 32'h3050);
    tbl[18] = mk(0, 0,  0,            6'h00, 0, 0,  0, 1, 0,            13, 0, 32'h800);
    tbl[19] = mk(0, 0,  0,            6'h00, 1, 4,  0, 0, 32'h3070,     13, 1, 32'h0);
    tbl[20] = mk(0, 0,  0,            6'h00, 0, 0,  0, 1, 0,            13, 0, 32'h10);
    tbl[21] = mk(1, 14, 32'h3007,     6'h00, 1, 10, 1, 0, 32'h3024,     14, 1, 32'h3070);
    tbl[22] = mk(0, 0,  0,            6'h00, 0, 0,  0, 0, 0,            14, 0, EPC_BD);
    tbl[23] = mk(0, 0,  0,            6'h00, 0, 0,  0, 1, 0,            13, 0, CAUSE_BD);
    tbl[24] = mk(1, 14, 32'h3007,     6'h00, 0, 0,  0, 0, 0,            14, 0, EPC_BD);
    tbl[25] = mk(0, 0,  0,            6'h00, 0, 0,  0, 0, 0,            14, 0, 32'h3004);
    tbl[26] = mk(1, 13, 32'hFFFF_FFFF, 6'h00, 0, 0, 0, 0, 0,            13, 0, CAUSE_BD);
    tbl[27] = mk(1, 15, 32'h1234_5678, 6'h00, 0, 0, 0, 0, 0,            13, 0, CAUSE_BD);
    tbl[28] = mk(0, 0,  0,            6'h00, 1, 0,  0, 0, 32'h3100,     15, 1, PRID);
    tbl[29] = mk(0, 0,  0,            6'h00, 0, 0,  0, 0, 0,            13, 0, 32'h0);
    tbl[30] = mk(0, 0,  0,            6'h00, 0, 0,  0, 0, 0,            14, 0, 32'h3100);

    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0));
    @(posedge clk); #1;
    check32("reset IntReq", {31'b0, IntReq}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 31; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // EXL is set here; a reset must clear everything despite live requests.
    reset = 1'b1;
    drive(mk(0, 0, 0, 6'h3F, 1, 3, 0, 0, 0, 12, 0, 0));
    @(posedge clk); #1;
    reset = 1'b0;
    apply("rst_mid sr", mk(0, 0, 0, 6'h3F, 0, 0, 0, 0, 0, 12, 0, 32'h0));
    apply("rst_mid cause", mk(0, 0, 0, 6'h00, 0, 0, 0, 0, 0, 13, 0, 32'hFC00));
    apply("rst_mid epc", mk(0, 0, 0, 6'h00, 0, 0, 0, 0, 0, 14, 0, EPC_RST));

    // Level-sensitive: a request dropped before IE is enabled is lost.
    apply("lvl arm", mk(1, 12, 32'h0000_FC00, 6'h3F, 0, 0, 0, 0, 0, 12, 0, 32'h0));
    apply("lvl drop", mk(1, 12, 32'h0000_FC01, 6'h00, 0, 0, 0, 0, 0, 12, 0, 32'hFC00));
    apply("lvl lost", mk(0, 0, 0, 6'h00, 0, 0, 0, 0, 0, 12, 0, 32'hFC01));

    // Randomized phase against the reference model.
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b0;
    m_reset();
    for (int n = 0; n < 2000; n++) begin
      bit rst;
      logic [4:0] regs [5];
      regs[0] = 12; regs[1] = 13; regs[2] = 14; regs[3] = 15; regs[4] = 5'($urandom);
      rst    = ($urandom_range(0, 99) == 0);
      rv.we  = ($urandom_range(0, 3) == 0);
      rv.a2  = regs[$urandom_range(0, 4)];
      rv.din = $urandom;
      rv.hw  = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom);
      rv.ev  = ($urandom_range(0, 7) == 0);
      rv.ec  = 5'($urandom);
      rv.bdi = 1'($urandom);
      rv.clr = ($urandom_range(0, 3) == 0);
      rv.pc  = $urandom;
      rv.a1  = regs[$urandom_range(0, 4)];
      reset  = rst;
      drive(rv);
      #2;
      check32("rand IntReq", {31'b0, IntReq}, {31'b0, m_int(rv.hw) || (rv.ev && !m_exl)});
      check32("rand DOut", DOut, m_read(rv.a1));
      check32("rand EPC", EPC, m_epc);
      m_step(rv, rst);
      @(posedge clk); #1;
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_int_ctrl.md
Name: cp0_int_ctrl

Overview:
- Receiving end of the device interrupt lines: a coprocessor-0-style interrupt and exception controller in the CPU.
- Samples the six hardware interrupt requests from the MMIO devices (timers and similar) and applies the SR mask and enable bits.
- Raises a single request to the pipeline and saves the return PC in EPC.
- Exposes SR, Cause, EPC and PRId to mfc0/mtc0; eret restores normal operation.

Parameters:
- PRID, 32'h0000_7F01, constant value returned when reading register 15.
- EPC_RST, 32'h0000_0000, reset value of EPC.

Ports:
- clk  in  1  clock.
- reset  in  1  Synchronous, active-high reset (reset reset, synchronous, active-high; clock clk).
- A1  in  5  mfc0 read register number.
- A2  in  5  mtc0 write register number.
- DIn  in  32  mtc0 write data.
- We  in  1  mtc0 write enable.
- PC  in  32  PC of the instruction in the commit stage.
- ExcValid  in  1  Synchronous exception present at the commit stage.
- ExcCode  in  5  Cause code for ExcValid.
- BDIn  in  1  Commit-stage instruction sits in a delay slot.
- HWInt  in  6  Device interrupt lines, bit0 = HWInt[2].
- EXLClr  in  1  eret committing.
- IntReq  out  1  Take interrupt/exception this cycle; flush the pipeline.
- EPC  out  32  Current EPC (eret target).
- DOut  out  32  mfc0 read data.

Behaviour:
- Register map, by register number:
  - 12 SR = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}
  - 13 Cause = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}
  - 14 EPC
  - 15 PRId
  - all other numbers read 0.
- Reset: IM=0, EXL=0, IE=0, IP=0, BD=0, ExcCode=0, EPC=EPC_RST. IntReq=0 during and after reset until the conditions below hold.
- Interrupt pending: int_pend = |(HWInt & IM) & IE & !EXL. This is combinational from the current HWInt and the registered SR.
- Exception pending: exc_pend = ExcValid & !EXL.
- Outputs are combinational, zero latency:
  - IntReq = int_pend | exc_pend.
  - DOut is driven from A1 and the current register contents.
- IP[15:10] <= HWInt every cycle, unconditionally, including during EXL=1.
- On a clock edge with IntReq=1 (entry):
  - EXL <= 1.
  - ExcCode <= 0 if int_pend, else ExcCode input. An interrupt has priority over a simultaneous exception.
  - EPC <= {PC[31:2], 2'b00}; BD <= 0 (see Optional Feature).
- mtc0, with We=1 and IntReq=0:
  - A2=12: IM <= DIn[15:10], EXL <= DIn[1], IE <= DIn[0].
  - A2=14: EPC <= {DIn[31:2], 2'b00}.
  - Cause and PRId are read-only; writes to them are ignored.
- mtc0 on the same edge as entry (We=1, IntReq=1): the write is discarded entirely, because the instruction is flushed.
- EXLClr=1 with IntReq=0: EXL <= 0 at the edge.
- EXLClr=1 while EXL=0: no effect.
- EXLClr and We to SR on the same edge: EXLClr wins for EXL; IM and IE take DIn.
- While EXL=1 (nesting forbidden): IntReq stays 0 regardless of HWInt or ExcValid. Pending lines remain visible in IP.
- Level-sensitive operation: a device deasserting HWInt before IE/EXL permit loses the request; no edge latching.
- Reset mid-operation (EXL=1) returns all fields to their reset values on the next edge.
- Read-during-write: DOut shows the old value in the write cycle and the new value in the following cycle.

Optional Feature:
- Macro: CP0_BD_EN.
- Defined:
  - On entry with BDIn=1: EPC <= {PC[31:2],2'b00} - 4 and BD <= 1.
  - On entry with BDIn=0: EPC <= PC and BD <= 0.
  - BD holds until the next entry.
- Undefined: BDIn is ignored, BD reads 0, and EPC <= PC always.

Test Plan:
- Reset, then read A1=12/13/14/15 -> DOut 0, 0, EPC_RST, 32'h0000_7F01; IntReq=0.
- mtc0 SR=32'h0000_0401, HWInt=6'b000001, PC=32'h0000_3010 -> IntReq=1 same cycle. Next cycle: SR reads 32'h0000_0403, Cause reads 32'h0000_0400, EPC reads 32'h0000_3010, IntReq=0.
- With EXL=1: ExcValid=1 and HWInt=6'b111111 -> IntReq stays 0 and Cause[15:10] reads 6'b111111. Then EXLClr=1 -> EXL=0 next cycle and IntReq=1 again (IM[10]=1, IE=1).
- SR=32'h0000_0801 (IM[11] only), HWInt=6'b000001 -> IntReq=0. Change HWInt to 6'b000010 -> IntReq=1.
- ExcValid=1, ExcCode=5'd4, HWInt enabled, same cycle -> ExcCode field 0 (interrupt wins). Repeat with HWInt=0 -> Cause reads 32'h0000_0010.
- CP0_BD_EN: BDIn=1, PC=32'h0000_3024, entry -> EPC 32'h0000_3020, Cause[31]=1. Without the macro: EPC 32'h0000_3024, Cause[31]=0. Also: mtc0 EPC with DIn=32'h0000_3007 concurrent with entry -> write dropped, EPC takes PC.
